fm_phase_discriminator: RTL and testbench
=========================================

# fm_phase_discriminator

Phase-difference FM discriminator placed directly downstream of the CORDIC vectoring stage. It consumes the CORDIC's per-sample phase angle, magnitude and valid strobe, and forms the wrapped phase difference between consecutive samples, which is the instantaneous frequency. It then averages and decimates blocks of `2**DECIM_LOG2` differences, applies a magnitude squelch, and outputs a signed frequency word with a valid strobe to the audio/baseband path.

## Interface
- `PH_BITS`, 32: width of the phase input (signed; full circle = `2**PH_BITS`, 90° ≈ `2**(PH_BITS-2)`)
- `XY_BITS`, 12: CORDIC coordinate width; the magnitude input is `XY_BITS+1` bits wide
- `DECIM_LOG2`, 2: log2 of the decimation/averaging factor (0 = no decimation)
- `OUT_BITS`, 16: output frequency word width, `OUT_BITS <= PH_BITS`
- `SQ_TH`, 64: squelch threshold on magnitude (unsigned)
- `DEEMPH_SHIFT`, 4: de-emphasis IIR coefficient shift (used only with the macro)

Ports:
- `clk_in` in 1: single clock
- `RST` in 1: asynchronous, active-high reset
- `phase_i` in `PH_BITS`: signed phase from CORDIC `phase_out`
- `mag_i` in `XY_BITS+1`: unsigned magnitude from CORDIC `magnitude`
- `valid_in` in 1: sample strobe from CORDIC `valid_out`
- `freq_o` out `OUT_BITS`: signed frequency word, held between strobes
- `squelch_o` out 1: the last emitted block was squelched
- `valid_out` out 1: one-cycle strobe marking a new `freq_o`

## Operation
- States:
  - PRIME: entered from reset. The first `valid_in` stores `phase_i` into `prev_ph`, emits no difference, and moves to RUN.
  - RUN: each `valid_in` computes `diff = phase_i - prev_ph` modulo `2**PH_BITS` (natural two's-complement wrap, no unwrap logic), then `prev_ph <= phase_i`.
- Accumulator:
  - Signed, `PH_BITS+DECIM_LOG2` wide; sign-extended `diff` values are summed.
  - Block counter `cnt` runs 0..`2**DECIM_LOG2-1`.
  - On the last diff of a block, `avg = (acc + diff) >>> DECIM_LOG2`, truncated to `PH_BITS`. The accumulator restarts at 0 and `cnt` wraps to 0.
- Output word: `freq_o = avg[PH_BITS-1 -: OUT_BITS]` (top bits, truncation, no rounding).
- Squelch:
  - A sticky flag `sq_blk` is set if any sample contributing to the block (current or previous phase) has `mag_i < SQ_TH`. This includes the priming sample.
  - At block end, if `sq_blk` is set, `freq_o <= 0` and `squelch_o <= 1`; otherwise `squelch_o <= 0`. `sq_blk` clears at block start.
- `valid_in` low: all state holds; gaps of any length are legal.
- Reset mid-block: the partial block is discarded, the FSM returns to PRIME, and the next sample re-primes.

## Timing
- Reset values: `freq_o = 0`, `squelch_o = 0`, `valid_out = 0`; `prev_ph`, `acc`, `cnt` and the de-emphasis state are 0; FSM is in PRIME.
- Pipeline:
  - Sample accepted at edge t.
  - `diff` registered at t+1.
  - Block-completing accumulation at t+2, with `freq_o`/`valid_out` updated at t+2.
  - Latency 2 cycles from the last sample of a block to the `valid_out` strobe; 3 cycles with the macro.
- Throughput: one sample per clock. Back-to-back `valid_in` is legal indefinitely.
- `valid_out` is high for exactly one cycle per `2**DECIM_LOG2` accepted diffs.
- The first block after reset completes on sample number `2**DECIM_LOG2 + 1`, because the first sample only primes.

## Configuration
- `FM_DEEMPHASIS_EN` defined: a one-pole IIR runs on each block output, `y <= y + ((avg - y) >>> DEEMPH_SHIFT)`, with `y` `PH_BITS` wide.
  - `freq_o` is taken from `y` instead of `avg`, and this adds one register stage.
  - Squelched blocks feed 0 into the IIR; they do not hold `y`.
- Not defined: the IIR is absent and `freq_o` comes straight from `avg`.

## Structure
- Shared package `demod_pkg`: the FSM state enum (PRIME, RUN) and a localparam helper for the accumulator width `PH_BITS+DECIM_LOG2`.
- The de-emphasis filter is a natural sub-module, `deemph_iir` (parameters `W`, `SHIFT`; ports `clk_in`, `RST`, `en`, `x`, `y`). It is instantiated only under `FM_DEEMPHASIS_EN`.

## Test plan
Benches use `PH_BITS=32`, `DECIM_LOG2=2`, `OUT_BITS=16`, `SQ_TH=64`, with the macro off unless stated.
- Constant ramp: `phase_i` advances by 0x01000000 per sample, `mag_i=1000`, valid every clock → first `valid_out` after sample 5, `freq_o=0x0100`, `squelch_o=0`, then one strobe every 4 samples.
- Wrap: phases 0x7F000000, 0x81000000, 0x83000000, … (step 0x02000000 across +π) → `freq_o=0x0200`, with no sign glitch.
- Negative frequency: step −0x00800000 per sample → `freq_o=0xFF80`.
- Squelch: one sample in a block has `mag_i=10` → that block gives `freq_o=0`, `squelch_o=1`; the next clean block gives `squelch_o=0` and the correct value.
- Reset after 2 samples of a block, then the ramp resumes → no `valid_out` until 5 further samples; the outputs read 0 during reset.
- With `FM_DEEMPHASIS_EN`: step from `avg=0` to `avg=0x10000000` with `DEEMPH_SHIFT=4` → `y` follows 0x01000000, 0x01F00000, … and the latency is 3 cycles.

Source files
------------

// File: rtl/demod_pkg.sv
// Shared types and width helpers for the FM demodulator datapath.
package demod_pkg;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } fsm_state_e;

  // Accumulator must hold 2**decim_log2 summed phase differences without overflow.
  function automatic int acc_width(input int ph_bits, input int decim_log2);
    return ph_bits + decim_log2;
  endfunction

  function automatic int cnt_width(input int decim_log2);
    return (decim_log2 < 1) ? 1 : decim_log2;
  endfunction

endpackage

// File: rtl/deemph_iir.sv
// One-pole de-emphasis low-pass: y <= y + ((x - y) >>> SHIFT), updated when en is high.
module deemph_iir #(
  parameter int W     = 32,
  parameter int SHIFT = 4
) (
  input  logic                clk_in,
  input  logic                RST,
  input  logic                en,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] y
);

  logic signed [W-1:0] y_q, y_d;
  logic signed [W:0]   delta;

  // One extra bit so x - y cannot overflow before the shift.
  always_comb begin
    delta = (W+1)'(x) - (W+1)'(y_q);
    y_d   = y_q;
    if (en) begin
      y_d = y_q + W'(delta >>> SHIFT);
    end
  end

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/fm_phase_discriminator.sv
// Phase-difference FM discriminator: wrapped phase delta, block average/decimate, magnitude squelch.
// Optional de-emphasis IIR on the block output is enabled with `define FM_DEEMPHASIS_EN.
module fm_phase_discriminator
  import demod_pkg::*;
#(
  parameter int PH_BITS      = 32,
  parameter int XY_BITS      = 12,
  parameter int DECIM_LOG2   = 2,
  parameter int OUT_BITS     = 16,
  parameter int SQ_TH        = 64,
  parameter int DEEMPH_SHIFT = 4
) (
  input  logic                clk_in,
  input  logic                RST,
  input  logic [PH_BITS-1:0]  phase_i,
  input  logic [XY_BITS:0]    mag_i,
  input  logic                valid_in,
  output logic [OUT_BITS-1:0] freq_o,
  output logic                squelch_o,
  output logic                valid_out
);

  localparam int ACC_W = acc_width(PH_BITS, DECIM_LOG2);
  localparam int CNT_W = cnt_width(DECIM_LOG2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);
  localparam logic [XY_BITS:0] SQ_TH_C  = (XY_BITS+1)'(SQ_TH);

  fsm_state_e state_q, state_d;
  logic [PH_BITS-1:0] prev_ph_q, prev_ph_d;
  logic               prev_lo_q, prev_lo_d;
  logic [PH_BITS-1:0] s1_cur_q, s1_cur_d, s1_prev_q, s1_prev_d;
  logic               s1_vld_q, s1_vld_d, s1_sq_q, s1_sq_d;
  logic [PH_BITS-1:0] diff_q, diff_d;
  logic               diff_vld_q, diff_vld_d, diff_sq_q, diff_sq_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sq_blk_q, sq_blk_d;
  logic               squelch_q, squelch_d;
  logic               valid_q, valid_d;

  logic                    mag_lo;
  logic signed [ACC_W-1:0] diff_ext, acc_sum, avg_full;
  logic [PH_BITS-1:0]      avg;
  logic                    blk_end, sq_any;

  assign mag_lo = (mag_i < SQ_TH_C);

  // Stage 1: FSM and sample capture. A low magnitude on either end of a diff taints it.
  always_comb begin
    state_d   = state_q;
    prev_ph_d = prev_ph_q;
    prev_lo_d = prev_lo_q;
    s1_vld_d  = 1'b0;
    s1_cur_d  = s1_cur_q;
    s1_prev_d = s1_prev_q;
    s1_sq_d   = s1_sq_q;
    if (valid_in) begin
      prev_ph_d = phase_i;
      prev_lo_d = mag_lo;
      case (state_q)
        ST_PRIME: state_d = ST_RUN;
        ST_RUN: begin
          s1_vld_d  = 1'b1;
          s1_cur_d  = phase_i;
          s1_prev_d = prev_ph_q;
          s1_sq_d   = mag_lo | prev_lo_q;
        end
        default: state_d = ST_PRIME;
      endcase
    end
  end

  // Stage 2: modular subtraction gives the wrapped difference with no unwrap logic.
  always_comb begin
    diff_vld_d = s1_vld_q;
    diff_d     = diff_q;
    diff_sq_d  = diff_sq_q;
    if (s1_vld_q) begin
      diff_d    = s1_cur_q - s1_prev_q;
      diff_sq_d = s1_sq_q;
    end
  end

  // Stage 3: block accumulate and average.
  always_comb begin
    diff_ext = ACC_W'(signed'(diff_q));
    acc_sum  = acc_q + diff_ext;
    avg_full = acc_sum >>> DECIM_LOG2;
    avg      = avg_full[PH_BITS-1:0];
    sq_any   = sq_blk_q | diff_sq_q;
    blk_end  = diff_vld_q && (cnt_q == CNT_LAST);
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sq_blk_d = sq_blk_q;
    if (diff_vld_q) begin
      if (blk_end) begin
        acc_d    = '0;
        cnt_d    = '0;
        sq_blk_d = 1'b0;
      end else begin
        acc_d    = acc_sum;
        cnt_d    = cnt_q + CNT_W'(1);
        sq_blk_d = sq_any;
      end
    end
  end

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      state_q    <= ST_PRIME;
      prev_ph_q  <= '0;
      prev_lo_q  <= 1'b0;
      s1_cur_q   <= '0;
      s1_prev_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_sq_q    <= 1'b0;
      diff_q     <= '0;
      diff_vld_q <= 1'b0;
      diff_sq_q  <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sq_blk_q   <= 1'b0;
      squelch_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_ph_q  <= prev_ph_d;
      prev_lo_q  <= prev_lo_d;
      s1_cur_q   <= s1_cur_d;
      s1_prev_q  <= s1_prev_d;
      s1_vld_q   <= s1_vld_d;
      s1_sq_q    <= s1_sq_d;
      diff_q     <= diff_d;
      diff_vld_q <= diff_vld_d;
      diff_sq_q  <= diff_sq_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sq_blk_q   <= sq_blk_d;
      squelch_q  <= squelch_d;
      valid_q    <= valid_d;
    end
  end

`ifdef FM_DEEMPHASIS_EN
  logic               blk_vld_q, blk_vld_d, blk_sq_q, blk_sq_d;
  logic [PH_BITS-1:0] blk_x_q, blk_x_d;
  logic [PH_BITS-1:0] y;

  // Squelched blocks drive zero into the filter so it decays rather than holds.
  always_comb begin
    blk_vld_d = blk_end;
    blk_sq_d  = blk_sq_q;
    blk_x_d   = blk_x_q;
    if (blk_end) begin
      blk_sq_d = sq_any;
      blk_x_d  = sq_any ? '0 : avg;
    end
    valid_d   = blk_vld_q;
    squelch_d = blk_vld_q ? blk_sq_q : squelch_q;
  end

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      blk_vld_q <= 1'b0;
      blk_sq_q  <= 1'b0;
      blk_x_q   <= '0;
    end else begin
      blk_vld_q <= blk_vld_d;
      blk_sq_q  <= blk_sq_d;
      blk_x_q   <= blk_x_d;
    end
  end

  deemph_iir #(
    .W     (PH_BITS),
    .SHIFT (DEEMPH_SHIFT)
  ) u_deemph (
    .clk_in (clk_in),
    .RST    (RST),
    .en     (blk_vld_q),
    .x      (blk_x_q),
    .y      (y)
  );

  assign freq_o = y[PH_BITS-1 -: OUT_BITS];
`else
  logic [OUT_BITS-1:0] freq_q, freq_d;

  always_comb begin
    valid_d   = blk_end;
    freq_d    = freq_q;
    squelch_d = squelch_q;
    if (blk_end) begin
      freq_d    = sq_any ? '0 : avg[PH_BITS-1 -: OUT_BITS];
      squelch_d = sq_any;
    end
  end

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      freq_q <= '0;
    end else begin
      freq_q <= freq_d;
    end
  end

  assign freq_o = freq_q;
`endif

  assign squelch_o = squelch_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_fm_phase_discriminator.sv
// Directed bench for fm_phase_discriminator (default build, de-emphasis off).
module tb_fm_phase_discriminator;

  logic        clk_in = 1'b0;
  logic        RST = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] phase_i = '0;
  logic [12:0] mag_i = '0;
  logic [15:0] freq_o;
  logic        squelch_o;
  logic        valid_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  int          exp_cyc_q[$];
  int          got_cyc_q[$];

  fm_phase_discriminator #(
    .PH_BITS      (32),
    .XY_BITS      (12),
    .DECIM_LOG2   (2),
    .OUT_BITS     (16),
    .SQ_TH        (64),
    .DEEMPH_SHIFT (4)
  ) dut (
    .clk_in    (clk_in),
    .RST       (RST),
    .phase_i   (phase_i),
    .mag_i     (mag_i),
    .valid_in  (valid_in),
    .freq_o    (freq_o),
    .squelch_o (squelch_o),
    .valid_out (valid_out)
  );

  // clock / cycle counter
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // strobe monitor
  always @(negedge clk_in) begin
    if (!RST && valid_out) begin
      got_q.push_back({squelch_o, freq_o});
      got_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] ph, input logic [12:0] mag);
    @(negedge clk_in);
    valid_in = 1'b1;
    phase_i  = ph;
    mag_i    = mag;
    last_acc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      valid_in = 1'b0;
    end
  endtask

  // Sends n samples start + i*step; sample lo_idx gets a low magnitude.
  // Each completed block expects exp_word, or squelch if its bit in sq_mask is set.
  task automatic ramp(input logic [31:0] start, input logic [31:0] step, input int n,
                      input logic [15:0] exp_word, input logic [7:0] sq_mask,
                      input int lo_idx, input int max_gap);
    logic [31:0] ph;
    for (int i = 0; i < n; i++) begin
      ph = start + step * i;
      send(ph, (i == lo_idx) ? 13'd10 : 13'd1000);
      if (i >= 4 && (i % 4) == 0) begin
        exp_q.push_back(sq_mask[(i / 4) - 1] ? 17'h10000 : {1'b0, exp_word});
        exp_cyc_q.push_back(last_acc + 2);
      end
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
    idle(4);
  endtask

  task automatic check_obs(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      chk({tag, "_word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      chk({tag, "_cycle"}, got_cyc_q.pop_front(), exp_cyc_q.pop_front());
    end
    exp_q.delete();
    got_q.delete();
    exp_cyc_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic do_reset();
    idle(3);
    @(negedge clk_in);
    RST = 1'b1;
    #1;
    chk("rst_freq", 32'(freq_o), 32'h0);
    chk("rst_squelch", 32'(squelch_o), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    @(negedge clk_in);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    #1;
    chk("por_freq", 32'(freq_o), 32'h0);
    chk("por_squelch", 32'(squelch_o), 32'h0);
    chk("por_valid", 32'(valid_out), 32'h0);
    @(negedge clk_in);
    RST = 1'b0;

    // constant ramp: blocks complete on samples 5, 9, 13
    ramp(32'h0000_0000, 32'h0100_0000, 13, 16'h0100, 8'h00, -1, 0);
    check_obs("ramp");
    chk("ramp_hold_freq", 32'(freq_o), 32'h0100);
    chk("ramp_hold_sq", 32'(squelch_o), 32'h0);

    // wrap across +pi
    do_reset();
    ramp(32'h7F00_0000, 32'h0200_0000, 9, 16'h0200, 8'h00, -1, 0);
    check_obs("wrap");

    // negative frequency
    do_reset();
    ramp(32'h0000_0000, 32'hFF80_0000, 9, 16'hFF80, 8'h00, -1, 0);
    check_obs("neg");

    // low magnitude mid block 1, block 2 clean
    do_reset();
    ramp(32'h0000_0000, 32'h0100_0000, 9, 16'h0100, 8'h01, 2, 0);
    check_obs("sq_mid");
    chk("sq_mid_hold", 32'(squelch_o), 32'h0);

    // low magnitude on the sample shared by blocks 1 and 2
    do_reset();
    ramp(32'h0000_0000, 32'h0100_0000, 13, 16'h0100, 8'h03, 4, 0);
    check_obs("sq_edge");

    // low magnitude on the priming sample
    do_reset();
    ramp(32'h1000_0000, 32'h0100_0000, 5, 16'h0100, 8'h01, 0, 0);
    check_obs("sq_prime");
    chk("sq_prime_hold_sq", 32'(squelch_o), 32'h1);
    chk("sq_prime_hold_freq", 32'(freq_o), 32'h0);

    // random gaps between samples
    do_reset();
    ramp(32'h0000_0000, 32'h0100_0000, 9, 16'h0100, 8'h00, -1, 3);
    check_obs("gaps");

    // reset two samples into a block, then a different ramp re-primes
    do_reset();
    ramp(32'h0000_0000, 32'h0100_0000, 7, 16'h0100, 8'h00, -1, 0);
    check_obs("pre_rst");
    chk("pre_rst_freq", 32'(freq_o), 32'h0100);
    do_reset();
    ramp(32'h2000_0000, 32'h0300_0000, 5, 16'h0300, 8'h00, -1, 0);
    check_obs("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
